// File: rtl/blk_a189c7.sv
// Operand prep for the invsqrt polynomial APM: y=|x-a| (saturated), z=y^2>>Y_W, a4+a6*z.
// Latency 3 enabled cycles, one set per cycle; no backpressure, i_ce=0 freezes every stage.
module blk_a189c7 #(
  parameter int X_W     = 24,
  parameter int Y_W     = 17,
  parameter int A5_W    = 22,
  parameter int A6_W    = 14,
  parameter int GRP_W   = 47,
  parameter int P_SHIFT = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic             i_valid,
  input  logic [X_W-1:0]   i_x,
  input  logic [X_W-1:0]   i_a,
  input  logic [GRP_W-1:0] i_a4,
  input  logic [A5_W-1:0]  i_a5,
  input  logic [A6_W-1:0]  i_a6,
  output logic             o_valid,
  output logic [GRP_W-1:0] o_a4_plus_a6_z,
  output logic             o_x_minus_a_is_pos,
  output logic [A5_W-1:0]  o_a5,
  output logic [Y_W-1:0]   o_y
);

  typedef struct packed {
    logic             vld;
    logic             pos;
    logic [Y_W-1:0]   y;
    logic [GRP_W-1:0] a4;
    logic [A5_W-1:0]  a5;
    logic [A6_W-1:0]  a6;
  } opnd_t;

  opnd_t s1, s2;
  logic [Y_W-1:0] s2_z;

  // Stage 1: signed difference at X_W+1 bits, magnitude, saturate into Y_W bits
  logic [X_W:0]   d;
  logic [X_W:0]   mag;
  logic           pos;
  logic           sat;
  logic [Y_W-1:0] y_nxt;

  always_comb begin
    d     = {1'b0, i_x} - {1'b0, i_a};
    pos   = (i_x >= i_a);
    mag   = pos ? d : -d;
    sat   = |(mag >> Y_W);
    y_nxt = sat ? {Y_W{1'b1}} : mag[Y_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= '0;
    end else if (i_ce) begin
      s1.vld <= i_valid;
      s1.pos <= pos;
      s1.y   <= y_nxt;
      s1.a4  <= i_a4;
      s1.a5  <= i_a5;
      s1.a6  <= i_a6;
    end
  end

  // Stage 2: square and keep the upper half
  logic [2*Y_W-1:0] sq;
  logic [Y_W-1:0]   z_nxt;

  always_comb begin
    sq    = {{Y_W{1'b0}}, s1.y} * {{Y_W{1'b0}}, s1.y};
    z_nxt = Y_W'(sq >> Y_W);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2   <= '0;
      s2_z <= '0;
    end else if (i_ce) begin
      s2   <= s1;
      s2_z <= z_nxt;
    end
  end

  // Stage 3: a4 + (a6*z >> P_SHIFT), wrapping at GRP_W bits
  logic [A6_W+Y_W-1:0] prod;
  logic [GRP_W-1:0]    sum;

  always_comb begin
    prod = {{Y_W{1'b0}}, s2.a6} * {{A6_W{1'b0}}, s2_z};
    sum  = s2.a4 + GRP_W'(prod >> P_SHIFT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid            <= 1'b0;
      o_a4_plus_a6_z     <= '0;
      o_x_minus_a_is_pos <= 1'b0;
      o_a5               <= '0;
      o_y                <= '0;
    end else if (i_ce) begin
      o_valid            <= s2.vld;
      o_a4_plus_a6_z     <= sum;
      o_x_minus_a_is_pos <= s2.pos;
      o_a5               <= s2.a5;
      o_y                <= s2.y;
    end
  end

endmodule

// File: tb/tb_blk_a189c7.sv
// Directed bench for blk_a189c7: vector table plus stall and mid-flight reset sequences.
module tb_blk_a189c7;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        valid;
  logic [23:0] x;
  logic [23:0] a;
  logic [46:0] a4;
  logic [21:0] a5;
  logic [13:0] a6;
  logic        o_valid;
  logic [46:0] o_sum;
  logic        o_pos;
  logic [21:0] o_a5;
  logic [16:0] o_y;

  int checks = 0;
  int errors = 0;

  blk_a189c7 dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_ce               (ce),
    .i_valid            (valid),
    .i_x                (x),
    .i_a                (a),
    .i_a4               (a4),
    .i_a5               (a5),
    .i_a6               (a6),
    .o_valid            (o_valid),
    .o_a4_plus_a6_z     (o_sum),
    .o_x_minus_a_is_pos (o_pos),
    .o_a5               (o_a5),
    .o_y                (o_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [87:0] snap();
    return {o_valid, o_pos, o_y, o_a5, o_sum};
  endfunction

  typedef struct {
    logic [23:0] x;
    logic [23:0] a;
    logic [46:0] a4;
    logic [21:0] a5;
    logic [13:0] a6;
    logic        pos;
    logic [16:0] y;
    logic [46:0] sum;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{24'h010080, 24'h000080, 47'd1000, 22'h155555, 14'd3, 1'b1, 17'd65536, 47'd99304};
    vecs[1] = '{24'h000010, 24'h000030, 47'd77, 22'h0aaaaa, 14'd5, 1'b0, 17'd32, 47'd77};
    vecs[2] = '{24'h800000, 24'h000000, 47'd0, 22'h3fffff, 14'd1, 1'b1, 17'd131071, 47'd131070};
    vecs[3] = '{24'd363, 24'd0, 47'h7fff_ffff_ffff, 22'h000001, 14'd1, 1'b1, 17'd363, 47'd0};
    vecs[4] = '{24'h123456, 24'h123456, 47'h1234_5678_9abc, 22'h000002, 14'h3fff, 1'b1, 17'd0, 47'h1234_5678_9abc};
    vecs[5] = '{24'h000000, 24'hffffff, 47'd5, 22'h000003, 14'h3fff, 1'b0, 17'd131071, 47'd2147319815};
    vecs[6] = '{24'd131071, 24'd0, 47'd0, 22'h000004, 14'd1, 1'b1, 17'd131071, 47'd131070};
    vecs[7] = '{24'h020005, 24'h000005, 47'd42, 22'h000005, 14'd0, 1'b1, 17'd131071, 47'd42};
    vecs[8] = '{24'h000100, 24'h000101, 47'd9, 22'h000006, 14'd7, 1'b0, 17'd1, 47'd9};

    rst = 1'b0; ce = 1'b1; valid = 1'b0;
    x = '0; a = '0; a4 = '0; a5 = '0; a6 = '0;

    // Asynchronous reset with no clock edge in between
    #1 rst = 1'b1;
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_sum", o_sum, 0);
    chk("reset_pos", o_pos, 0);
    chk("reset_a5", o_a5, 0);
    chk("reset_y", o_y, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single-set vectors: result after edge n+2, one-cycle valid pulse
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      x = vecs[i].x; a = vecs[i].a; a4 = vecs[i].a4; a5 = vecs[i].a5; a6 = vecs[i].a6;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      x = 24'h5a5a5a; a = 24'h0000a5; a4 = 47'h1111; a5 = 22'h2222; a6 = 14'h33;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), o_valid, 1);
      chk($sformatf("vec%0d_pos", i), o_pos, vecs[i].pos);
      chk($sformatf("vec%0d_y", i), o_y, vecs[i].y);
      chk($sformatf("vec%0d_sum", i), o_sum, vecs[i].sum);
      chk($sformatf("vec%0d_a5", i), o_a5, vecs[i].a5);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pulse", i), o_valid, 0);
    end

    // Back-to-back sets with a two-cycle stall after the second
    begin
      int          nrecv;
      logic        prev_ce;
      logic [87:0] prev_snap;
      int          set_idx;
      nrecv = 0;
      prev_ce = 1'b1;
      prev_snap = '0;
      for (int k = 0; k < 14; k++) begin
        @(negedge clk);
        if (k > 0) begin
          if (!prev_ce) begin
            chk($sformatf("stall_frozen_k%0d", k), snap(), prev_snap);
          end else if (o_valid) begin
            if (nrecv < 4) begin
              chk($sformatf("stall_set%0d_y", nrecv), o_y, 17'(nrecv + 1));
              chk($sformatf("stall_set%0d_sum", nrecv), o_sum, 47'(100 + nrecv));
              chk($sformatf("stall_set%0d_a5", nrecv), o_a5, 22'(16 + nrecv));
              chk($sformatf("stall_set%0d_pos", nrecv), o_pos, 1);
            end else begin
              chk("stall_extra_valid", o_valid, 0);
            end
            nrecv++;
          end
        end
        prev_snap = snap();
        ce = !(k == 2 || k == 3);
        prev_ce = ce;
        set_idx = (k == 0) ? 0 : (k == 1) ? 1 : (k <= 4) ? 2 : 3;
        if (k < 6) begin
          valid = 1'b1;
          x = 24'(set_idx + 1); a = '0; a6 = 14'd9;
          a4 = 47'(100 + set_idx); a5 = 22'(16 + set_idx);
        end else begin
          valid = 1'b0;
          x = 24'h5555; a = 24'h1; a4 = 47'h77; a5 = 22'h99; a6 = 14'h1;
        end
      end
      chk("stall_count", nrecv, 4);
    end

    // Reset while three sets are in flight
    ce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid = 1'b1;
      x = 24'h010080 + 24'(k); a = 24'h80; a4 = 47'd1000; a5 = 22'h155555; a6 = 14'd3;
    end
    @(negedge clk);
    valid = 1'b0;
    chk("rst_pre_valid", o_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_sum", o_sum, 0);
    chk("rst_mid_pos", o_pos, 0);
    chk("rst_mid_a5", o_a5, 0);
    chk("rst_mid_y", o_y, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_no_stale_%0d", k), o_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
